pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage MIPS pipeline. It generates PCWrite for the PC register and write-enable/flush controls for the IF/ID, ID/EX and EX/MEM pipeline registers. It resolves four hazard sources:
- load-use hazards,
- multi-cycle MDU (mult/div) occupancy of EX,
- instruction-memory wait,
- branch/jump redirects resolved in EX/MEM.

A registered FSM plus a down-counter sequences the MDU stall; all other controls are combinational from inputs and state.

---
 rtl/pipe_hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for a 5-stage MIPS pipeline.
// Resolves branch/jump redirects, multi-cycle MDU occupancy of EX,
// load-use hazards and instruction-memory wait, in that priority order.
// Optional macro HAZ_PERF_EN builds the 32-bit saturating stall/redirect
// performance counters; without it both counter ports read as zero.
module pipe_hazard_ctrl #(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        EM_PCSrc,
    input  logic [1:0]  EM_jump,
    input  logic        DE_mem_read,
    input  logic [4:0]  DE_rt,
    input  logic        DE_mdu_start,
    input  logic [4:0]  FD_rs,
    input  logic [4:0]  FD_rt,
    input  logic        FD_uses_rt,
    input  logic        imem_ready,
    output logic        PCWrite,
    output logic        FD_write,
    output logic        FD_flush,
    output logic        DE_write,
    output logic        DE_flush,
    output logic        EM_flush,
    output logic        mdu_busy,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    typedef enum logic {
        RUN = 1'b0,
        MDU = 1'b1
    } state_t;

    localparam logic MULTI_CYCLE = (MDU_LAT > 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 2);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    logic redirect;
    logic load_use;
    logic mdu_hold;

    // Hazard detection terms
    always_comb begin
        redirect = EM_PCSrc | (EM_jump != 2'b00);
        load_use = DE_mem_read & (DE_rt != 5'd0) &
                   ((DE_rt == FD_rs) | (FD_uses_rt & (DE_rt == FD_rt)));
        mdu_hold = ((state == RUN) & DE_mdu_start & MULTI_CYCLE) |
                   ((state == MDU) & (cnt != '0));
    end

    // FSM state and MDU down-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state: a redirect aborts any MDU stall; the release cycle
    // (MDU with cnt==0) ignores DE_mdu_start and returns to RUN.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (redirect) begin
            state_next = RUN;
            cnt_next   = '0;
        end else begin
            case (state)
                RUN: begin
                    if (DE_mdu_start && MULTI_CYCLE) begin
                        state_next = MDU;
                        cnt_next   = CNT_LOAD;
                    end
                end
                MDU: begin
                    if (cnt != '0) begin
                        cnt_next = cnt - 1'b1;
                    end else begin
                        state_next = RUN;
                    end
                end
                default: begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Pipeline controls, strict priority: redirect > mdu > load-use > fetch wait
    always_comb begin
        PCWrite  = 1'b1;
        FD_write = 1'b1;
        DE_write = 1'b1;
        FD_flush = 1'b0;
        DE_flush = 1'b0;
        EM_flush = 1'b0;
        if (redirect) begin
            FD_flush = 1'b1;
            DE_flush = 1'b1;
        end else if (mdu_hold) begin
            PCWrite  = 1'b0;
            FD_write = 1'b0;
            DE_write = 1'b0;
            EM_flush = 1'b1;
        end else if (load_use) begin
            PCWrite  = 1'b0;
            FD_write = 1'b0;
            DE_flush = 1'b1;
        end else if (!imem_ready) begin
            PCWrite  = 1'b0;
            FD_flush = 1'b1;
        end
    end

    // Busy flag decoded straight from the state register
    always_comb begin
        mdu_busy = (state == MDU);
    end

`ifdef HAZ_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    // Saturating counters of stalled-PC cycles and redirect cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!PCWrite && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (redirect && (flush_cnt != 32'hFFFF_FFFF)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

    // Counter outputs
    always_comb begin
        perf_stall_cnt = stall_cnt;
        perf_flush_cnt = flush_cnt;
    end
`else
    // Counters not built
    always_comb begin
        perf_stall_cnt = 32'h0;
        perf_flush_cnt = 32'h0;
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios followed by random
// stimulus, checked against a cycle-level reference model via a scoreboard.
module tb_pipe_hazard_ctrl;

    localparam int LAT = 4;
    localparam int EW  = 71;

    logic        clk;
    logic        rst_n;
    logic        EM_PCSrc;
    logic [1:0]  EM_jump;
    logic        DE_mem_read;
    logic [4:0]  DE_rt;
    logic        DE_mdu_start;
    logic [4:0]  FD_rs;
    logic [4:0]  FD_rt;
    logic        FD_uses_rt;
    logic        imem_ready;
    logic        PCWrite;
    logic        FD_write;
    logic        FD_flush;
    logic        DE_write;
    logic        DE_flush;
    logic        EM_flush;
    logic        mdu_busy;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;

    pipe_hazard_ctrl #(.MDU_LAT(LAT), .CNT_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .EM_PCSrc      (EM_PCSrc),
        .EM_jump       (EM_jump),
        .DE_mem_read   (DE_mem_read),
        .DE_rt         (DE_rt),
        .DE_mdu_start  (DE_mdu_start),
        .FD_rs         (FD_rs),
        .FD_rt         (FD_rt),
        .FD_uses_rt    (FD_uses_rt),
        .imem_ready    (imem_ready),
        .PCWrite       (PCWrite),
        .FD_write      (FD_write),
        .FD_flush      (FD_flush),
        .DE_write      (DE_write),
        .DE_flush      (DE_flush),
        .EM_flush      (EM_flush),
        .mdu_busy      (mdu_busy),
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: {PCWrite,FD_write,FD_flush,DE_write,DE_flush,EM_flush,mdu_busy,stall,flush}
    logic [EW-1:0] exp_q[$];

    // Reference model: remaining cycles the MDU op still spends in EX
    // beyond the first, plus running perf totals.
    int          ex_left;
    logic [31:0] m_stall;
    logic [31:0] m_flush;

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] dut_vec();
        return {PCWrite, FD_write, FD_flush, DE_write, DE_flush, EM_flush, mdu_busy,
                perf_stall_cnt, perf_flush_cnt};
    endfunction

    // Compute this cycle's expected outputs from the hazard rules, then advance the model
    task automatic model_step(input logic pcsrc, input logic [1:0] jmp, input logic mr,
                              input logic [4:0] drt, input logic st, input logic [4:0] rs,
                              input logic [4:0] rt, input logic urt, input logic rdy);
        logic redir, ld, busy, hold, start_new;
        logic pcw, fdw, fdf, dew, def_, emf;
        logic [31:0] es, ef;
        redir = pcsrc || (jmp != 2'b00);
        ld    = mr && (drt != 0) && ((drt == rs) || (urt && (drt == rt)));
        busy  = (ex_left > 0);
        start_new = !busy && st && (LAT > 1);
        hold  = start_new || (ex_left > 1);
        {pcw, fdw, dew, fdf, def_, emf} = 6'b111000;
        if (redir)        begin fdf = 1; def_ = 1; end
        else if (hold)    begin pcw = 0; fdw = 0; dew = 0; emf = 1; end
        else if (ld)      begin pcw = 0; fdw = 0; def_ = 1; end
        else if (!rdy)    begin pcw = 0; fdf = 1; end
`ifdef HAZ_PERF_EN
        es = m_stall;
        ef = m_flush;
`else
        es = 32'h0;
        ef = 32'h0;
`endif
        exp_q.push_back({pcw, fdw, fdf, dew, def_, emf, busy, es, ef});
        if (!pcw) m_stall++;
        if (redir) m_flush++;
        if (redir)          ex_left = 0;
        else if (start_new) ex_left = LAT - 1;
        else if (busy)      ex_left--;
    endtask

    // Driver: apply one cycle of inputs just after the clock edge
    task automatic drive(input logic pcsrc, input logic [1:0] jmp, input logic mr,
                         input logic [4:0] drt, input logic st, input logic [4:0] rs,
                         input logic [4:0] rt, input logic urt, input logic rdy);
        @(posedge clk);
        #1;
        EM_PCSrc = pcsrc; EM_jump = jmp; DE_mem_read = mr; DE_rt = drt;
        DE_mdu_start = st; FD_rs = rs; FD_rt = rt; FD_uses_rt = urt; imem_ready = rdy;
        model_step(pcsrc, jmp, mr, drt, st, rs, rt, urt, rdy);
    endtask

    task automatic idle();
        drive(0, 2'b00, 0, 5'd0, 0, 5'd0, 5'd0, 0, 1);
    endtask

    task automatic set_idle_inputs();
        EM_PCSrc = 0; EM_jump = 2'b00; DE_mem_read = 0; DE_rt = 0;
        DE_mdu_start = 0; FD_rs = 0; FD_rt = 0; FD_uses_rt = 0; imem_ready = 1;
    endtask

    // Monitor: outputs are present every cycle; compare mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            check("cycle_outputs", dut_vec(), e);
        end
    end

    initial begin
        set_idle_inputs();
        ex_left = 0;
        m_stall = 0;
        m_flush = 0;
        rst_n = 1'b0;
        #12;
        check("reset_state", dut_vec(), {7'b1101000, 64'h0});
        @(negedge clk);
        rst_n = 1'b1;

        // Load-use, then clear; then rt==0 gives no stall
        drive(0, 2'b00, 1, 5'd5, 0, 5'd5, 5'd0, 0, 1);
        idle();
        drive(0, 2'b00, 1, 5'd0, 0, 5'd0, 5'd0, 1, 1);
        // Load-use through rt
        drive(0, 2'b00, 1, 5'd7, 0, 5'd1, 5'd7, 1, 1);
        drive(0, 2'b00, 1, 5'd7, 0, 5'd1, 5'd7, 0, 1);

        // MDU with start held across the whole occupancy
        for (int i = 0; i < LAT; i++) drive(0, 2'b00, 0, 5'd0, 1, 5'd0, 5'd0, 0, 1);
        idle();
        idle();

        // Redirect in the second hold cycle
        drive(0, 2'b00, 0, 5'd0, 1, 5'd0, 5'd0, 0, 1);
        drive(1, 2'b00, 0, 5'd0, 0, 5'd0, 5'd0, 0, 1);
        idle();
        idle();

        // Redirect beats load-use and fetch wait
        drive(0, 2'b10, 1, 5'd3, 0, 5'd3, 5'd0, 0, 0);
        // Fetch wait for two cycles
        drive(0, 2'b00, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0);
        drive(0, 2'b00, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0);
        // Back-to-back MDU ops
        drive(0, 2'b00, 0, 5'd0, 1, 5'd0, 5'd0, 0, 1);
        for (int i = 0; i < LAT; i++) drive(0, 2'b00, 1, 5'd2, 1, 5'd2, 5'd0, 0, 0);
        idle();

        // Reset asserted during an MDU hold
        drive(0, 2'b00, 0, 5'd0, 1, 5'd0, 5'd0, 0, 1);
        drive(0, 2'b00, 0, 5'd0, 0, 5'd0, 5'd0, 0, 1);
        @(negedge clk);
        #2;
        set_idle_inputs();
        rst_n = 1'b0;
        #1;
        check("async_reset_busy", {70'h0, mdu_busy}, {EW{1'b0}});
        check("async_reset_outputs", dut_vec(), {7'b1101000, 64'h0});
        ex_left = 0;
        m_stall = 0;
        m_flush = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic pcsrc, mr, st, urt, rdy;
            logic [1:0] jmp;
            logic [4:0] drt, rs, rt;
            pcsrc = ($urandom_range(0, 99) < 7);
            jmp   = ($urandom_range(0, 99) < 6) ? 2'($urandom_range(1, 3)) : 2'b00;
            mr    = ($urandom_range(0, 99) < 35);
            drt   = 5'($urandom_range(0, 3));
            st    = ($urandom_range(0, 99) < 20);
            rs    = 5'($urandom_range(0, 3));
            rt    = 5'($urandom_range(0, 3));
            urt   = $urandom_range(0, 1);
            rdy   = ($urandom_range(0, 99) < 80);
            drive(pcsrc, jmp, mr, drt, st, rs, rt, urt, rdy);
        end
        idle();

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
